// File: rtl/ledshift_checker_pkg.sv
// Shared encodings for the ledshift bus checker: FSM states, error codes and counter width.
package ledshift_checker_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, TRACK, ERROR} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_ONEHOT, ERR_STEP, ERR_STALL} err_t;
  localparam int STEP_W = 16;
endpackage

// File: rtl/ledshift_checker_onehot_enc.sv
// One-hot to index encoder with a flag telling whether exactly one bit is set.
module onehot_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 is_onehot
);
  localparam int IW = $clog2(W);

  always_comb begin
    idx       = '0;
    is_onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    for (int i = 0; i < W; i++)
      if (vec[i]) idx = IW'(i);
  end
endmodule

// File: rtl/ledshift_checker.sv
// Samples the walking one-hot LED bus, tracks position/steps/wraps and flags protocol errors.
module ledshift_checker
  import ledshift_checker_pkg::*;
#(
  parameter int W        = 8,
  parameter int DIR      = 0,
  parameter int MAX_HOLD = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [W-1:0]         i_led,
  output logic [$clog2(W)-1:0] o_pos,
  output logic                 o_valid,
  output logic [STEP_W-1:0]    o_steps,
  output logic                 o_wrap,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);
  localparam int IW = $clog2(W);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  state_t            state, state_n;
  logic [W-1:0]      r_led, r_prev, exp_led;
  logic [HW-1:0]     hold, hold_n;
  logic [IW-1:0]     idx, pos_n;
  logic              onehot, valid_n, wrap_n, err_n, is_wrap;
  logic [STEP_W-1:0] steps_n;
  err_t              code_n;

  onehot_enc #(.W(W)) u_enc (.vec(r_led), .idx(idx), .is_onehot(onehot));

  // Expected next pattern is r_prev rotated by one in the configured direction
  always_comb begin
    if (DIR == 0) begin
      exp_led = {r_prev[W-2:0], r_prev[W-1]};
      is_wrap = r_prev[W-1] & r_led[0];
    end else begin
      exp_led = {r_prev[0], r_prev[W-1:1]};
      is_wrap = r_prev[0] & r_led[W-1];
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = o_pos;
    valid_n = o_valid;
    steps_n = o_steps;
    wrap_n  = 1'b0;
    err_n   = o_err;
    code_n  = err_t'(o_err_code);
    hold_n  = hold;
    if (i_stop) begin
      state_n = IDLE;
      valid_n = 1'b0;
    end else if (i_start) begin
      state_n = ARMED;
      steps_n = '0;
      err_n   = 1'b0;
      code_n  = ERR_NONE;
      valid_n = 1'b0;
    end else begin
      case (state)
        ARMED: if (r_led != '0) begin
          if (onehot) begin
            state_n = TRACK;
            pos_n   = idx;
            valid_n = 1'b1;
            steps_n = '0;
            hold_n  = '0;
          end else begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = ERR_ONEHOT;
          end
        end
        TRACK: begin
          if (r_led == r_prev) begin
            if (hold == HOLD_LIM) begin
              state_n = ERROR;
              err_n   = 1'b1;
              code_n  = ERR_STALL;
              valid_n = 1'b0;
            end else begin
              hold_n = hold + 1'b1;
            end
          end else if (!onehot) begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = ERR_ONEHOT;
            valid_n = 1'b0;
          end else if (r_led != exp_led) begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = ERR_STEP;
            valid_n = 1'b0;
          end else begin
            pos_n  = idx;
            hold_n = '0;
            wrap_n = is_wrap;
            if (o_steps != '1) steps_n = o_steps + 1'b1;
          end
        end
        ERROR:   valid_n = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_led      <= '0;
      r_prev     <= '0;
      hold       <= '0;
      o_pos      <= '0;
      o_valid    <= 1'b0;
      o_steps    <= '0;
      o_wrap     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
    end else begin
      state      <= state_n;
      r_led      <= i_led;
      r_prev     <= r_led;
      hold       <= hold_n;
      o_pos      <= pos_n;
      o_valid    <= valid_n;
      o_steps    <= steps_n;
      o_wrap     <= wrap_n;
      o_err      <= err_n;
      o_err_code <= code_n;
    end
  end
endmodule

// File: tb/tb_ledshift_checker.sv
// Scoreboard bench for ledshift_checker (W=8, DIR=0, MAX_HOLD=20) with directed LED sequences.
module tb_ledshift_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [7:0]  i_led = '0;
  logic [2:0]  o_pos;
  logic        o_valid;
  logic [15:0] o_steps;
  logic        o_wrap;
  logic        o_err;
  logic [1:0]  o_err_code;

  ledshift_checker #(.W(8), .DIR(0), .MAX_HOLD(20)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_led(i_led),
    .o_pos(o_pos), .o_valid(o_valid), .o_steps(o_steps), .o_wrap(o_wrap),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  pos;
    logic        valid;
    logic [15:0] steps;
    logic        err;
    logic [1:0]  code;
    int          wraps;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wraps_seen = 0;
  int   exp_wraps = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input int pos, input int valid,
                            input int steps, input int err, input int code);
    exp_t e;
    e.name  = n;
    e.pos   = 3'(pos);
    e.valid = 1'(valid);
    e.steps = 16'(steps);
    e.err   = 1'(err);
    e.code  = 2'(code);
    e.wraps = exp_wraps;
    q.push_back(e);
  endtask

  // Pulse start with v on the bus; two edges later the checker is tracking at v
  task automatic arm_at(input logic [7:0] v);
    i_led   = v;
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    cyc(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_wrap) wraps_seen++;
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (o_pos !== e.pos || o_valid !== e.valid || o_steps !== e.steps ||
          o_err !== e.err || o_err_code !== e.code || wraps_seen != e.wraps) begin
        miscompares++;
        $display("FAIL %s: got pos=%0d valid=%0b steps=%0d err=%0b code=%0d wraps=%0d, want pos=%0d valid=%0b steps=%0d err=%0b code=%0d wraps=%0d",
                 e.name, o_pos, o_valid, o_steps, o_err, o_err_code, wraps_seen,
                 e.pos, e.valid, e.steps, e.err, e.code, e.wraps);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(1);
    expect_out("reset", 0, 0, 0, 0, 0);

    // full walk with one wrap
    arm_at(8'h01);
    expect_out("arm01", 0, 1, 0, 0, 0);
    cyc(8);
    for (int k = 1; k < 8; k++) begin
      i_led = 8'(1 << k);
      cyc(10);
      expect_out($sformatf("walk%0d", k), k, 1, k, 0, 0);
    end
    i_led = 8'h01;
    cyc(10);
    exp_wraps = 1;
    expect_out("wrap", 0, 1, 8, 0, 0);

    // not one-hot
    arm_at(8'h08);
    expect_out("arm08", 3, 1, 0, 0, 0);
    i_led = 8'h0C;
    cyc(2);
    expect_out("onehot_err", 3, 0, 0, 1, 1);

    // wrong step, then restart clears errors
    arm_at(8'h04);
    i_led = 8'h20;
    cyc(2);
    expect_out("step_err", 2, 0, 0, 1, 2);
    cyc(3);
    expect_out("step_err_frozen", 2, 0, 0, 1, 2);
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
    expect_out("restart_clear", 2, 0, 0, 0, 0);

    // stall after 21 unchanged cycles
    arm_at(8'h10);
    cyc(20);
    expect_out("hold20_ok", 4, 1, 0, 0, 0);
    cyc(1);
    expect_out("stall_err", 4, 0, 0, 1, 3);

    // start+stop together: stop wins, results frozen
    arm_at(8'h01);
    i_led = 8'h02;
    cyc(2);
    expect_out("step1", 1, 1, 1, 0, 0);
    i_led = 8'h04;
    cyc(2);
    expect_out("step2", 2, 1, 2, 0, 0);
    i_start = 1'b1;
    i_stop  = 1'b1;
    cyc(1);
    i_start = 1'b0;
    i_stop  = 1'b0;
    expect_out("stop_wins", 2, 0, 2, 0, 0);
    i_led = 8'h08;
    cyc(3);
    expect_out("idle_frozen", 2, 0, 2, 0, 0);

    // async reset mid-track
    arm_at(8'h01);
    for (int k = 1; k < 6; k++) begin
      i_led = 8'(1 << k);
      cyc(2);
    end
    expect_out("steps5", 5, 1, 5, 0, 0);
    cyc(1);
    rst = 1'b1;
    expect_out("async_rst", 0, 0, 0, 0, 0);
    cyc(2);
    rst = 1'b0;
    i_led = 8'h40;
    cyc(3);
    expect_out("post_rst_idle", 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
